// File: rtl/serial_bit_tx.sv
// Serial transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Optional parity stage is enabled by defining SERIAL_TX_PARITY_EN.
module serial_bit_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             o,
    output logic             busy_o,
    output logic             done_o
);

    // Counter must also reach STOP_BITS-1 when WIDTH is very small.
    localparam int unsigned DATA_CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned STOP_CNT_W = $clog2(STOP_BITS + 1);
    localparam int unsigned CNT_W      = (DATA_CNT_W > STOP_CNT_W) ? DATA_CNT_W : STOP_CNT_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               o_q, o_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            o_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state, bit counter and shift register
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    shift_d = data_i;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^data_i;
`endif
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                shift_d = shift_q >> 1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                    cnt_d = '0;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                state_d = ST_STOP;
                cnt_d   = '0;
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with it
    always_comb begin
        o_d    = 1'b0;
        busy_d = (state_d != ST_IDLE);
        done_d = 1'b0;
        case (state_d)
            ST_START: o_d = 1'b1;
            ST_DATA:  o_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: o_d = parity_d;
`endif
            ST_STOP:  done_d = (cnt_d == CNT_W'(STOP_BITS - 1));
            default:  o_d = 1'b0;
        endcase
    end

    assign ready_o = (state_q == ST_IDLE) & ~rst;
    assign o       = o_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx: two instances (8b/1 stop and 4b/3 stop) checked
// cycle by cycle against a queue-of-line-bits reference model.
module tb_serial_bit_tx;

    localparam int unsigned WA = 8;
    localparam int unsigned SA = 1;
    localparam int unsigned WB = 4;
    localparam int unsigned SB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          ready_a, o_a, busy_a, done_a;
    logic          ready_b, o_b, busy_b, done_b;

    int unsigned   n_vec = 0;
    int unsigned   n_bad = 0;
    int unsigned   cyc = 0;

    // Remaining line bits of the frame in flight; element 0 is on the line now
    bit qa[$];
    bit qb[$];

    always #5 clk = ~clk;

    serial_bit_tx #(.WIDTH(WA), .STOP_BITS(SA)) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data),
        .valid_i (valid),
        .ready_o (ready_a),
        .o       (o_a),
        .busy_o  (busy_a),
        .done_o  (done_a)
    );

    serial_bit_tx #(.WIDTH(WB), .STOP_BITS(SB)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data[WB-1:0]),
        .valid_i (valid),
        .ready_o (ready_b),
        .o       (o_b),
        .busy_o  (busy_b),
        .done_o  (done_b)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive at negedge, check ready, update model at posedge, check outputs
    task automatic cycle(input logic r, input logic v, input logic [7:0] d);
        bit exp_ra, exp_rb;
        rst   = r;
        valid = v;
        data  = d;
        #1;
        exp_ra = (qa.size() == 0) && !r;
        exp_rb = (qb.size() == 0) && !r;
        check("ready_a", ready_a, exp_ra);
        check("ready_b", ready_b, exp_rb);
        @(posedge clk);
        cyc++;
        if (r) begin
            qa.delete();
            qb.delete();
        end else begin
            if (qa.size() > 0) qa.pop_front();
            else if (v) begin
                qa.push_back(1'b1);
                for (int i = 0; i < WA; i++) qa.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
                qa.push_back(^d);
`endif
                for (int i = 0; i < SA; i++) qa.push_back(1'b0);
            end
            if (qb.size() > 0) qb.pop_front();
            else if (v) begin
                qb.push_back(1'b1);
                for (int i = 0; i < WB; i++) qb.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
                qb.push_back(^d[WB-1:0]);
`endif
                for (int i = 0; i < SB; i++) qb.push_back(1'b0);
            end
        end
        @(negedge clk);
        check("o_a",    o_a,    (qa.size() > 0) ? qa[0] : 1'b0);
        check("busy_a", busy_a, qa.size() > 0);
        check("done_a", done_a, qa.size() == 1);
        check("o_b",    o_b,    (qb.size() > 0) ? qb[0] : 1'b0);
        check("busy_b", busy_b, qb.size() > 0);
        check("done_b", done_b, qb.size() == 1);
    endtask

    initial begin
        // Reset held for three cycles, then released
        repeat (3) cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // Single frame of 8'hA5 (4'h5 on the narrow instance)
        cycle(1'b0, 1'b1, 8'hA5);
        repeat (14) cycle(1'b0, 1'b0, 8'h00);

        // 4'hF frame on the narrow instance with three stop bits
        cycle(1'b0, 1'b1, 8'h0F);
        repeat (14) cycle(1'b0, 1'b0, 8'h00);

        // Valid held high across back-to-back frames
        cycle(1'b0, 1'b1, 8'h01);
        repeat (26) cycle(1'b0, 1'b1, 8'h02);
        repeat (14) cycle(1'b0, 1'b0, 8'h00);

        // Parity contrast words
        cycle(1'b0, 1'b1, 8'h07);
        repeat (14) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h03);
        repeat (14) cycle(1'b0, 1'b0, 8'h00);

        // Reset during the fourth data bit, then an immediate new word
        cycle(1'b0, 1'b1, 8'hA5);
        repeat (4) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h3C);
        repeat (14) cycle(1'b0, 1'b0, 8'h00);

        // Randomised traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0),
                  8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
